zero_one_event_monitor: RTL

ZERO_ONE_EVENT_MONITOR -- requirements
Module: zero_one_event_monitor

---
 rtl/zero_one_event_monitor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/zero_one_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : zero_one_event_monitor
// Description : Counts 0->1 detector pulses over fixed windows of WIN_LEN
//               sample cycles. At each window close it reports the count,
//               raises an alarm when the count reaches a threshold, and keeps
//               a saturating running total of every event it sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module zero_one_event_monitor #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16,
    parameter int TOT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             det,
    input  logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] win_count,
    output logic             win_valid,
    output logic             alarm,
    output logic [TOT_W-1:0] total,
    output logic             busy
);

    // Index only has to reach WIN_LEN-1, so WIN_LEN = 2^16 still fits 16 bits.
    localparam int IDX_W = $clog2(WIN_LEN);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_COUNT   = 2'd1;
    localparam logic [1:0]       c_REPORT  = 2'd2;
    localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [TOT_W-1:0] c_TOT_MAX = '1;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_win_count;
    logic             r_win_valid;
    logic             r_alarm;
    logic [TOT_W-1:0] r_total;
    logic             r_busy;

    logic [CNT_W-1:0] w_acc_next;
    logic [TOT_W-1:0] w_tot_next;
    logic             w_last;

    // Saturating increments of the window accumulator and the running total.
    always_comb begin
        w_acc_next = r_acc;
        w_tot_next = r_total;
        if (det && (r_acc != c_CNT_MAX)) begin
            w_acc_next = r_acc + CNT_W'(1);
        end
        if (det && (r_total != c_TOT_MAX)) begin
            w_tot_next = r_total + TOT_W'(1);
        end
        w_last = (r_idx == c_LAST);
    end

    // Window state machine; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_win_count <= '0;
            r_win_valid <= 1'b0;
            r_alarm     <= 1'b0;
            r_total     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_win_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (en) begin
                        r_state <= c_COUNT;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_COUNT: begin
                    if (!en) begin
                        // Abort: this cycle's det is dropped, report registers hold.
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_total <= w_tot_next;
                        if (w_last) begin
                            r_state     <= c_REPORT;
                            r_busy      <= 1'b0;
                            r_win_count <= w_acc_next;
                            r_alarm     <= (w_acc_next >= thresh);
                            r_win_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            r_acc <= w_acc_next;
                        end
                    end
                end
                c_REPORT: begin
                    if (en) begin
                        r_state <= c_COUNT;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign win_count = r_win_count;
    assign win_valid = r_win_valid;
    assign alarm     = r_alarm;
    assign total     = r_total;
    assign busy      = r_busy;

endmodule
`default_nettype wire
